// File: rtl/hazard_sched_if.sv
// D-stage hazard query bundle: operand/producer info in, stall and forward selects out.
// master drives the D-stage instruction fields; slave is the scheduler answering combinationally.
interface hazard_sched_if;
    logic [4:0] A1_D;
    logic [4:0] A2_D;
    logic [1:0] Tuse_rs;
    logic [1:0] Tuse_rt;
    logic [4:0] A3_D;
    logic [1:0] Tnew_D;
    logic       md_start_D;
    logic       md_is_div_D;
    logic       md_use_D;
    logic       stall;
    logic [1:0] MF_RD1_Sel;
    logic [1:0] MF_RD2_Sel;
    logic       md_busy;

    modport master (
        output A1_D, A2_D, Tuse_rs, Tuse_rt, A3_D, Tnew_D,
               md_start_D, md_is_div_D, md_use_D,
        input  stall, MF_RD1_Sel, MF_RD2_Sel, md_busy
    );

    modport slave (
        input  A1_D, A2_D, Tuse_rs, Tuse_rt, A3_D, Tnew_D,
               md_start_D, md_is_div_D, md_use_D,
        output stall, MF_RD1_Sel, MF_RD2_Sel, md_busy
    );
endinterface

// File: rtl/hazard_sched.sv
// Tuse/Tnew hazard scheduler: stall and forward selects are combinational on D-stage fields,
// the E/M scoreboard and mult/div counter update every clock; stall is the only backpressure.
module hazard_sched #(
    parameter int MD_MULT_CYCLES = 5,
    parameter int MD_DIV_CYCLES  = 10
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           flush,
    hazard_sched_if.slave  hz
);
    typedef struct packed {
        logic       valid;
        logic [4:0] a3;
        logic [1:0] tnew;
    } slot_t;

    localparam logic [3:0] MD_MULT_LD = 4'(MD_MULT_CYCLES);
    localparam logic [3:0] MD_DIV_LD  = 4'(MD_DIV_CYCLES);

    // W results reach D through the register-file bypass and are never compared
    // against, so only the E and M producers are tracked.
    slot_t      slot_e;
    slot_t      slot_m;
    logic [3:0] md_cnt;
    logic       stall_int;
    logic       busy_int;

    function automatic slot_t age_slot(input slot_t s);
        slot_t r;
        r = s;
        if (s.tnew != 2'd0) r.tnew = s.tnew - 2'd1;
        return r;
    endfunction

    function automatic logic match(input slot_t s, input logic [4:0] a);
        return s.valid && (s.a3 == a) && (a != 5'd0);
    endfunction

    function automatic logic need_stall(input logic [4:0] a, input logic [1:0] tuse,
                                        input slot_t e, input slot_t m);
        return (match(e, a) && (e.tnew > tuse)) || (match(m, a) && (m.tnew > tuse));
    endfunction

    // Youngest producer first: a result sitting in E shadows an older one in M.
    function automatic logic [1:0] fwd_sel(input logic [4:0] a, input slot_t e, input slot_t m);
        if (match(e, a) && (e.tnew == 2'd0)) return 2'b10;
        if (match(m, a) && (m.tnew == 2'd0)) return 2'b01;
        return 2'b00;
    endfunction

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            slot_e <= '0;
            slot_m <= '0;
            md_cnt <= '0;
        end else begin
            slot_m <= age_slot(slot_e);
            slot_e <= stall_int ? slot_t'('0) : slot_t'({1'b1, hz.A3_D, hz.Tnew_D});
            if (!stall_int && hz.md_start_D)
                md_cnt <= hz.md_is_div_D ? MD_DIV_LD : MD_MULT_LD;
            else if (md_cnt != 4'd0)
                md_cnt <= md_cnt - 4'd1;
        end
    end

    always_comb begin
        busy_int  = (md_cnt != 4'd0);
        stall_int = need_stall(hz.A1_D, hz.Tuse_rs, slot_e, slot_m)
                  | need_stall(hz.A2_D, hz.Tuse_rt, slot_e, slot_m)
                  | (hz.md_use_D && busy_int);
    end

    always_comb begin
        hz.stall      = stall_int;
        hz.md_busy    = busy_int;
        hz.MF_RD1_Sel = fwd_sel(hz.A1_D, slot_e, slot_m);
        hz.MF_RD2_Sel = fwd_sel(hz.A2_D, slot_e, slot_m);
    end
endmodule

// File: tb/tb_hazard_sched.sv
// Bench for hazard_sched: directed pipeline scenarios plus random instruction streams
// compared against an age-based reference model of producer readiness.
module tb_hazard_sched;
    logic clk = 1'b0;
    logic reset;
    logic flush;
    always #5 clk = ~clk;

    hazard_sched_if hz();

    hazard_sched dut (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .hz    (hz)
    );

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model: the two most recent issue slots by age (0 = in E, 1 = in M).
    // A producer issued with latency t is ready once it has aged t cycles.
    logic       pv[2];
    logic [4:0] pa[2];
    int         pt[2];
    int         cyc     = 0;
    int         md_free = 0;
    bit         model_ok = 1'b0;

    logic       obs_stall;
    logic       obs_busy;
    logic [1:0] obs_s1;
    logic [1:0] obs_s2;

    function automatic int remaining(input int k);
        return (pt[k] > k) ? pt[k] - k : 0;
    endfunction

    function automatic bit hit(input int k, input logic [4:0] a);
        return pv[k] && (pa[k] == a) && (a != 5'd0);
    endfunction

    function automatic bit model_stall(input logic [4:0] a, input int tuse);
        for (int k = 0; k < 2; k++)
            if (hit(k, a) && remaining(k) > tuse) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [1:0] model_sel(input logic [4:0] a);
        for (int k = 0; k < 2; k++)
            if (hit(k, a) && remaining(k) == 0) return (k == 0) ? 2'b10 : 2'b01;
        return 2'b00;
    endfunction

    // One D-stage cycle: drive, sample at negedge, compare with the model, then age the model.
    task automatic step(input logic rst, input logic fl,
                        input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] a3,
                        input logic [1:0] tr, input logic [1:0] tt, input logic [1:0] tn,
                        input logic ms, input logic md, input logic mu);
        bit es;
        bit eb;
        reset = rst;
        flush = fl;
        hz.A1_D = a1;  hz.A2_D = a2;  hz.A3_D = a3;
        hz.Tuse_rs = tr; hz.Tuse_rt = tt; hz.Tnew_D = tn;
        hz.md_start_D = ms; hz.md_is_div_D = md; hz.md_use_D = mu;
        @(negedge clk);
        obs_stall = hz.stall;
        obs_busy  = hz.md_busy;
        obs_s1    = hz.MF_RD1_Sel;
        obs_s2    = hz.MF_RD2_Sel;
        eb = (cyc < md_free);
        es = model_stall(a1, int'(tr)) || model_stall(a2, int'(tt)) || (mu && eb);
        if (model_ok) begin
            check_eq("stall", {31'd0, obs_stall}, {31'd0, es});
            check_eq("md_busy", {31'd0, obs_busy}, {31'd0, eb});
            check_eq("sel_rs", {30'd0, obs_s1}, {30'd0, model_sel(a1)});
            check_eq("sel_rt", {30'd0, obs_s2}, {30'd0, model_sel(a2)});
        end
        @(posedge clk);
        cyc++;
        if (rst || fl) begin
            for (int k = 0; k < 2; k++) begin
                pv[k] = 1'b0; pa[k] = 5'd0; pt[k] = 0;
            end
            md_free = 0;
            if (rst) model_ok = 1'b1;
        end else begin
            pv[1] = pv[0]; pa[1] = pa[0]; pt[1] = pt[0];
            pv[0] = !es;   pa[0] = a3;    pt[0] = int'(tn);
            if (!es && ms) md_free = cyc + (md ? 10 : 5);
        end
        #1;
    endtask

    task automatic nop();
        step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 2'd3, 2'd3, 2'd0, 1'b0, 1'b0, 1'b0);
    endtask

    logic [4:0] regs[5];
    int n;

    initial begin
        regs[0] = 5'd0; regs[1] = 5'd1; regs[2] = 5'd2; regs[3] = 5'd3; regs[4] = 5'd31;
        for (int k = 0; k < 2; k++) begin
            pv[k] = 1'b0; pa[k] = 5'd0; pt[k] = 0;
        end

        step(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 2'd3, 2'd3, 2'd0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 2'd3, 2'd3, 2'd0, 1'b0, 1'b0, 1'b0);
        nop();
        check_eq("rst_stall", {31'd0, obs_stall}, 32'd0);
        check_eq("rst_busy", {31'd0, obs_busy}, 32'd0);
        check_eq("rst_sel_rs", {30'd0, obs_s1}, 32'd0);
        check_eq("rst_sel_rt", {30'd0, obs_s2}, 32'd0);

        // lw $1 ; addu $3,$1,$2
        step(1'b0, 1'b0, 5'd0, 5'd0, 5'd1, 2'd3, 2'd3, 2'd2, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 5'd1, 5'd2, 5'd3, 2'd1, 2'd1, 2'd1, 1'b0, 1'b0, 1'b0);
        check_eq("lw_use_stall", {31'd0, obs_stall}, 32'd1);
        step(1'b0, 1'b0, 5'd1, 5'd2, 5'd3, 2'd1, 2'd1, 2'd1, 1'b0, 1'b0, 1'b0);
        check_eq("lw_use_release", {31'd0, obs_stall}, 32'd0);
        nop(); nop();

        // jal ; jr $31
        step(1'b0, 1'b0, 5'd0, 5'd0, 5'd31, 2'd3, 2'd3, 2'd0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 5'd31, 5'd0, 5'd0, 2'd0, 2'd3, 2'd0, 1'b0, 1'b0, 1'b0);
        check_eq("jr_stall", {31'd0, obs_stall}, 32'd0);
        check_eq("jr_sel", {30'd0, obs_s1}, 32'd2);
        nop(); nop();

        // addu $5 ; beq $5,$0
        step(1'b0, 1'b0, 5'd0, 5'd0, 5'd5, 2'd3, 2'd3, 2'd1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 5'd5, 5'd0, 5'd0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0);
        check_eq("beq_stall", {31'd0, obs_stall}, 32'd1);
        step(1'b0, 1'b0, 5'd5, 5'd0, 5'd0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0);
        check_eq("beq_release", {31'd0, obs_stall}, 32'd0);
        check_eq("beq_sel", {30'd0, obs_s1}, 32'd1);
        nop(); nop();

        // producers of $0 never stall or forward
        step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 2'd3, 2'd3, 2'd2, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 2'd3, 2'd3, 2'd0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0);
        check_eq("zero_stall", {31'd0, obs_stall}, 32'd0);
        check_eq("zero_sel_rs", {30'd0, obs_s1}, 32'd0);
        check_eq("zero_sel_rt", {30'd0, obs_s2}, 32'd0);
        nop(); nop();

        // mult then mflo, div then mflo
        for (int d = 0; d < 2; d++) begin
            step(1'b0, 1'b0, 5'd1, 5'd2, 5'd0, 2'd1, 2'd1, 2'd0, 1'b1, d[0], 1'b1);
            n = 0;
            for (int i = 0; i < 20; i++) begin
                step(1'b0, 1'b0, 5'd0, 5'd0, 5'd4, 2'd3, 2'd3, 2'd1, 1'b0, 1'b0, 1'b1);
                if (i == 0) check_eq("md_busy_first", {31'd0, obs_busy}, 32'd1);
                if (!obs_stall) break;
                n++;
            end
            check_eq(d ? "div_stall_cycles" : "mult_stall_cycles", n, d ? 32'd10 : 32'd5);
        end
        nop(); nop();

        // lw $1 in E, reader stalls, flush clears the scoreboard
        step(1'b0, 1'b0, 5'd0, 5'd0, 5'd1, 2'd3, 2'd3, 2'd2, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 5'd1, 5'd0, 5'd0, 2'd0, 2'd3, 2'd0, 1'b0, 1'b0, 1'b0);
        check_eq("flush_cycle_stall", {31'd0, obs_stall}, 32'd1);
        step(1'b0, 1'b0, 5'd1, 5'd0, 5'd0, 2'd0, 2'd3, 2'd0, 1'b0, 1'b0, 1'b0);
        check_eq("post_flush_stall", {31'd0, obs_stall}, 32'd0);
        check_eq("post_flush_sel", {30'd0, obs_s1}, 32'd0);

        for (int i = 0; i < 3000; i++) begin
            logic ms;
            ms = ($urandom_range(0, 7) == 0);
            step($urandom_range(0, 199) == 0, $urandom_range(0, 49) == 0,
                 regs[$urandom_range(0, 4)], regs[$urandom_range(0, 4)], regs[$urandom_range(0, 4)],
                 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 2)),
                 ms, 1'($urandom_range(0, 1)), ms | ($urandom_range(0, 3) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
